usb_tx_ctrl: RTL

USB_TX_CTRL -- requirements
Module: usb_tx_ctrl

---
 rtl/usb_pkg.sv | 27 ++
 rtl/usb_nrzi_enc.sv | 45 ++++
 rtl/usb_tx_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// ============================================================================
// Module   : usb_pkg
// Purpose  : Shared types and line constants for the USB transmit path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package usb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_SYNC = 3'd1,
        SEND_DATA = 3'd2,
        EOP_SE0   = 3'd3,
        EOP_J     = 3'd4
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    // Line pairs are {d_plus, d_minus}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage

`default_nettype wire

// File: rtl/usb_nrzi_enc.sv
// ============================================================================
// Module   : usb_nrzi_enc
// Purpose  : NRZI encoder and D+/D- pair driver; init restarts the level at J.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_nrzi_enc
    import usb_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic bit_in,
    input  logic bit_strobe,
    input  logic se0,
    input  logic init,
    output logic d_plus,
    output logic d_minus
);

    logic r_level;
    logic w_base;
    logic w_next;

    // A 0 bit toggles the level, a 1 bit holds it
    assign w_base = init ? 1'b1 : r_level;
    assign w_next = bit_in ? w_base : ~w_base;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_level            <= 1'b1;
            {d_plus, d_minus}  <= LINE_J;
        end else if (bit_strobe) begin
            if (se0) begin
                {d_plus, d_minus} <= LINE_SE0;
            end else begin
                r_level           <= w_next;
                {d_plus, d_minus} <= w_next ? LINE_J : LINE_K;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/usb_tx_ctrl.sv
// ============================================================================
// Module   : usb_tx_ctrl
// Purpose  : USB low-level packet transmitter: SYNC, FIFO data bytes, EOP.
//            Optional bit stuffing is enabled by defining USB_TX_BITSTUFF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_tx_ctrl
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
)
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic       tx_empty,
    input  logic [7:0] tx_data,
    output logic       get_data,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int            TW         = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

    tx_state_t     r_state;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_idx;
    logic          r_tx_busy;
    logic          r_tx_done;

    logic       w_tick;
    logic       w_sending;
    logic       w_need_stuff;
    logic       w_byte_end;
    logic [2:0] w_next_idx;
    logic       w_strobe;
    logic       w_bit;
    logic       w_se0;
    logic       w_init;

`ifdef USB_TX_BITSTUFF_EN
    logic [2:0] r_ones;

    // Counts consecutive 1s already on the line, across byte boundaries
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ones <= 3'd0;
        end else if (w_strobe && !w_se0) begin
            r_ones <= w_bit ? r_ones + 3'd1 : 3'd0;
        end
    end

    assign w_need_stuff = (r_ones == 3'd6);
`else
    assign w_need_stuff = 1'b0;
`endif

    assign w_tick     = (r_timer == TIMER_LAST);
    assign w_sending  = (r_state == SEND_SYNC) || (r_state == SEND_DATA);
    assign w_byte_end = w_sending && w_tick && (r_bit_idx == 3'd7) && !w_need_stuff;
    assign w_next_idx = r_bit_idx + 3'd1;
    assign get_data   = w_byte_end && !tx_empty;
    assign tx_busy    = r_tx_busy;
    assign tx_done    = r_tx_done;

    // Line update request for the bit period starting on the next edge
    always_comb begin
        w_strobe = 1'b0;
        w_bit    = 1'b1;
        w_se0    = 1'b0;
        w_init   = 1'b0;
        case (r_state)
            IDLE: begin
                if (tx_start) begin
                    w_strobe = 1'b1;
                    w_init   = 1'b1;
                    w_bit    = SYNC_BYTE[0];
                end
            end
            SEND_SYNC, SEND_DATA: begin
                if (w_tick) begin
                    w_strobe = 1'b1;
                    if (w_need_stuff) begin
                        w_bit = 1'b0;
                    end else if (r_bit_idx == 3'd7) begin
                        if (!tx_empty) begin
                            w_bit = tx_data[0];
                        end else begin
                            w_se0 = 1'b1;
                        end
                    end else begin
                        w_bit = r_shift[w_next_idx];
                    end
                end
            end
            EOP_SE0: begin
                if (w_tick && r_bit_idx[0]) begin
                    w_strobe = 1'b1;
                    w_init   = 1'b1;
                    w_bit    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_shift   <= 8'h00;
            r_bit_idx <= 3'd0;
            r_tx_busy <= 1'b0;
            r_tx_done <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            if (r_state == IDLE || w_tick) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TW'(1);
            end
            case (r_state)
                IDLE: begin
                    if (tx_start) begin
                        r_state   <= SEND_SYNC;
                        r_shift   <= SYNC_BYTE;
                        r_bit_idx <= 3'd0;
                        r_tx_busy <= 1'b1;
                    end
                end
                SEND_SYNC, SEND_DATA: begin
                    // A stuffed bit holds the shift position for one period
                    if (w_tick && !w_need_stuff) begin
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= 3'd0;
                            if (!tx_empty) begin
                                r_shift <= tx_data;
                                r_state <= SEND_DATA;
                            end else begin
                                r_state <= EOP_SE0;
                            end
                        end else begin
                            r_bit_idx <= w_next_idx;
                        end
                    end
                end
                EOP_SE0: begin
                    if (w_tick) begin
                        if (r_bit_idx[0]) begin
                            r_state   <= EOP_J;
                            r_bit_idx <= 3'd0;
                        end else begin
                            r_bit_idx <= w_next_idx;
                        end
                    end
                end
                EOP_J: begin
                    if (w_tick) begin
                        r_state   <= IDLE;
                        r_tx_busy <= 1'b0;
                        r_tx_done <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_tx_busy <= 1'b0;
                end
            endcase
        end
    end

    usb_nrzi_enc u_nrzi_enc (
        .clk        (clk),
        .n_rst      (n_rst),
        .bit_in     (w_bit),
        .bit_strobe (w_strobe),
        .se0        (w_se0),
        .init       (w_init),
        .d_plus     (d_plus),
        .d_minus    (d_minus)
    );

endmodule

`default_nettype wire
